// File: rtl/sap_ctrl_if.sv
// Control-word bundle from the SAP microsequencer to the datapath.
// Strobes are active-low except pc_inc and alu_sub.
interface sap_ctrl_if;
  logic pc_inc;
  logic pc_oe_n;
  logic pc_ld_n;
  logic mar_ld_n;
  logic ram_oe_n;
  logic ir_ld_n;
  logic ir_oe_n;
  logic acc_ld_n;
  logic acc_oe_n;
  logic b_ld_n;
  logic alu_oe_n;
  logic alu_sub;
  logic out_ld_n;

  modport master (
    output pc_inc, pc_oe_n, pc_ld_n, mar_ld_n,
    output ram_oe_n, ir_ld_n, ir_oe_n,
    output acc_ld_n, acc_oe_n, b_ld_n,
    output alu_oe_n, alu_sub, out_ld_n
  );

  modport slave (
    input pc_inc, pc_oe_n, pc_ld_n, mar_ld_n,
    input ram_oe_n, ir_ld_n, ir_oe_n,
    input acc_ld_n, acc_oe_n, b_ld_n,
    input alu_oe_n, alu_sub, out_ld_n
  );
endinterface

// File: rtl/sap_ctrl.sv
// SAP microsequencer: six-state fetch/execute ring plus retired count.
// Optional JMP (opcode 0x3) enabled by defining SAP_CTRL_JMP_EN.
module sap_ctrl #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  sap_ctrl_if.master       cw,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_lda, is_sub, is_arith, is_out, is_hlt, is_jmp;

  assign is_lda   = (opcode == OP_LDA);
  assign is_sub   = (opcode == OP_SUB);
  assign is_arith = (opcode == OP_ADD) || is_sub;
  assign is_out   = (opcode == OP_OUT);
  assign is_hlt   = (opcode == OP_HLT);

`ifdef SAP_CTRL_JMP_EN
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h3);
  assign is_jmp = (opcode == OP_JMP);
`else
  assign is_jmp = 1'b0;
`endif

  // Active-high internal strobes; inverted onto the bus below.
  logic inc, pc_oe, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe;
  logic acc_ld, acc_oe, b_ld, alu_oe, sub, out_ld;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    pc_oe   = 1'b0;
    pc_ld   = 1'b0;
    mar_ld  = 1'b0;
    ram_oe  = 1'b0;
    ir_ld   = 1'b0;
    ir_oe   = 1'b0;
    acc_ld  = 1'b0;
    acc_oe  = 1'b0;
    b_ld    = 1'b0;
    alu_oe  = 1'b0;
    sub     = 1'b0;
    out_ld  = 1'b0;
    unique case (state_q)
      IDLE: if (run) state_d = T1;
      T1: begin
        pc_oe   = 1'b1;
        mar_ld  = 1'b1;
        state_d = T2;
      end
      T2: begin
        inc     = 1'b1;
        state_d = T3;
      end
      T3: begin
        ram_oe  = 1'b1;
        ir_ld   = 1'b1;
        state_d = T4;
      end
      T4: begin
        ir_oe   = is_lda || is_arith || is_jmp;
        mar_ld  = is_lda || is_arith;
        pc_ld   = is_jmp;
        acc_oe  = is_out;
        out_ld  = is_out;
        state_d = T5;
        if (is_hlt) begin
          state_d = HALT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      T5: begin
        ram_oe  = is_lda || is_arith;
        acc_ld  = is_lda;
        b_ld    = is_arith;
        state_d = T6;
      end
      T6: begin
        alu_oe  = is_arith;
        acc_ld  = is_arith;
        sub     = is_sub;
        state_d = run ? T1 : IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      HALT: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cw.pc_inc   = inc;
  assign cw.pc_oe_n  = ~pc_oe;
  assign cw.pc_ld_n  = ~pc_ld;
  assign cw.mar_ld_n = ~mar_ld;
  assign cw.ram_oe_n = ~ram_oe;
  assign cw.ir_ld_n  = ~ir_ld;
  assign cw.ir_oe_n  = ~ir_oe;
  assign cw.acc_ld_n = ~acc_ld;
  assign cw.acc_oe_n = ~acc_oe;
  assign cw.b_ld_n   = ~b_ld;
  assign cw.alu_oe_n = ~alu_oe;
  assign cw.alu_sub  = sub;
  assign cw.out_ld_n = ~out_ld;

  assign halted    = (state_q == HALT);
  assign busy      = (state_q != IDLE) && (state_q != HALT);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap_ctrl.sv
// Bench for sap_ctrl: per-cycle vector table plus hand sequences
// for halt hold, async reset, jump decode and counter wrap.
module tb_sap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       halted, busy;
  logic [7:0] instr_cnt;
  logic [12:0] got;

  sap_ctrl_if bus ();

  sap_ctrl #(.OP_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .cw        (bus),
    .halted    (halted),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  assign got = {bus.pc_inc, bus.pc_oe_n, bus.pc_ld_n, bus.mar_ld_n,
                bus.ram_oe_n, bus.ir_ld_n, bus.ir_oe_n, bus.acc_ld_n,
                bus.acc_oe_n, bus.b_ld_n, bus.alu_oe_n, bus.alu_sub,
                bus.out_ld_n};

  localparam logic [12:0] M_PCINC  = 13'h1000;
  localparam logic [12:0] M_PCOE   = 13'h0800;
  localparam logic [12:0] M_PCLD   = 13'h0400;
  localparam logic [12:0] M_MARLD  = 13'h0200;
  localparam logic [12:0] M_RAMOE  = 13'h0100;
  localparam logic [12:0] M_IRLD   = 13'h0080;
  localparam logic [12:0] M_IROE   = 13'h0040;
  localparam logic [12:0] M_ACCLD  = 13'h0020;
  localparam logic [12:0] M_ACCOE  = 13'h0010;
  localparam logic [12:0] M_BLD    = 13'h0008;
  localparam logic [12:0] M_ALUOE  = 13'h0004;
  localparam logic [12:0] M_ALUSUB = 13'h0002;
  localparam logic [12:0] M_OUTLD  = 13'h0001;
  localparam logic [12:0] IDL      = 13'h0FFD;

  localparam logic [12:0] W_T1 = IDL ^ (M_PCOE | M_MARLD);
  localparam logic [12:0] W_T2 = IDL ^ M_PCINC;
  localparam logic [12:0] W_T3 = IDL ^ (M_RAMOE | M_IRLD);
  localparam logic [12:0] W_MA = IDL ^ (M_IROE | M_MARLD);
  localparam logic [12:0] W_LA = IDL ^ (M_RAMOE | M_ACCLD);
  localparam logic [12:0] W_LB = IDL ^ (M_RAMOE | M_BLD);
  localparam logic [12:0] W_SB = IDL ^ (M_ALUOE | M_ACCLD | M_ALUSUB);
  localparam logic [12:0] W_OT = IDL ^ (M_ACCOE | M_OUTLD);

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic [12:0] cw;
    logic        busy;
    logic        halted;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tv[27];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t mk(logic r, logic [3:0] o, logic [12:0] w,
                              logic b, logic h, logic [7:0] c);
    vec_t v;
    v.run = r; v.op = o; v.cw = w; v.busy = b; v.halted = h; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mk(0, 4'h0, IDL,  0, 0, 0);
    tv[1]  = mk(1, 4'h0, IDL,  0, 0, 0);
    tv[2]  = mk(1, 4'h0, W_T1, 1, 0, 0);
    tv[3]  = mk(1, 4'h0, W_T2, 1, 0, 0);
    tv[4]  = mk(1, 4'h0, W_T3, 1, 0, 0);
    tv[5]  = mk(1, 4'h0, W_MA, 1, 0, 0);
    tv[6]  = mk(1, 4'h0, W_LA, 1, 0, 0);
    tv[7]  = mk(1, 4'h0, IDL,  1, 0, 0);
    tv[8]  = mk(1, 4'h2, W_T1, 1, 0, 1);
    tv[9]  = mk(1, 4'h2, W_T2, 1, 0, 1);
    tv[10] = mk(1, 4'h2, W_T3, 1, 0, 1);
    tv[11] = mk(1, 4'h2, W_MA, 1, 0, 1);
    tv[12] = mk(1, 4'h2, W_LB, 1, 0, 1);
    tv[13] = mk(1, 4'h2, W_SB, 1, 0, 1);
    tv[14] = mk(1, 4'hE, W_T1, 1, 0, 2);
    tv[15] = mk(1, 4'hE, W_T2, 1, 0, 2);
    tv[16] = mk(0, 4'hE, W_T3, 1, 0, 2);
    tv[17] = mk(0, 4'hE, W_OT, 1, 0, 2);
    tv[18] = mk(0, 4'hE, IDL,  1, 0, 2);
    tv[19] = mk(0, 4'hE, IDL,  1, 0, 2);
    tv[20] = mk(0, 4'hF, IDL,  0, 0, 3);
    tv[21] = mk(1, 4'hF, IDL,  0, 0, 3);
    tv[22] = mk(1, 4'hF, W_T1, 1, 0, 3);
    tv[23] = mk(1, 4'hF, W_T2, 1, 0, 3);
    tv[24] = mk(1, 4'hF, W_T3, 1, 0, 3);
    tv[25] = mk(1, 4'hF, IDL,  1, 0, 3);
    tv[26] = mk(1, 4'hF, IDL,  0, 1, 4);

    tick();
    chk("rst_cw", 32'(got), 32'(IDL));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      run = tv[i].run;
      opcode = tv[i].op;
      #1;
      chk($sformatf("v%0d_cw", i), 32'(got), 32'(tv[i].cw));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_halt", i), 32'(halted), 32'(tv[i].halted));
      chk($sformatf("v%0d_cnt", i), 32'(instr_cnt), 32'(tv[i].cnt));
    end

    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hold%0d", i),
          {16'(got), 8'(instr_cnt), 7'(0), halted},
          {16'(IDL), 8'd4, 7'(0), 1'b1});
    end

    #2 rst_n = 1'b0;
    #1;
    chk("arst_halt", 32'(halted), 0);
    chk("arst_cnt", 32'(instr_cnt), 0);
    chk("arst_cw", 32'(got), 32'(IDL));

    tick();
    rst_n = 1'b1;
    run = 1'b1;
    opcode = 4'h0;
    for (int i = 0; i < 7; i++) tick();
    chk("lda_cnt1", 32'(instr_cnt), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_t5", 32'(got), 32'(W_LA));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cw", 32'(got), 32'(IDL));
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(instr_cnt), 0);

    tick();
    rst_n = 1'b1;
    opcode = 4'h3;
    for (int i = 0; i < 4; i++) tick();
`ifdef SAP_CTRL_JMP_EN
    chk("jmp_t4", 32'(got), 32'(IDL ^ (M_IROE | M_PCLD)));
`else
    chk("jmp_t4", 32'(got), 32'(IDL));
`endif
    tick();
    chk("jmp_t5", 32'(got), 32'(IDL));

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    opcode = 4'h5;
    begin
      int gaps;
      gaps = 0;
      for (int i = 0; i < 256 * 6; i++) begin
        tick();
        if (busy !== 1'b1) gaps++;
        if (i == 255 * 6) chk("nop_cnt255", 32'(instr_cnt), 255);
      end
      chk("nop_gaps", 32'(gaps), 0);
    end
    tick();
    chk("wrap_cnt", 32'(instr_cnt), 0);
    chk("wrap_t1", 32'(got), 32'(W_T1));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sap_ctrl.md
# sap_ctrl

Microsequencer for the 8-bit accumulator CPU. It steps a fixed six-state fetch/execute ring and drives the active-low load/enable strobes of the program counter, MAR, RAM, instruction register, accumulator, B register, ALU and output register. It decodes the 4-bit opcode from the instruction register. It also keeps a retired-instruction counter and a halt flag for the top level.

## Interface

Parameters:
- OP_W, 4, opcode width (fixed by the ISA; do not change).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- opcode  input  4  IR upper nibble; valid from T4 onward.
- pc_inc  output  1  active-high PC increment.
- pc_oe_n  output  1  PC drives the bus.
- pc_ld_n  output  1  PC loads from the bus (jump).
- mar_ld_n  output  1  MAR load.
- ram_oe_n  output  1  RAM drives the bus.
- ir_ld_n  output  1  IR load.
- ir_oe_n  output  1  IR operand nibble drives the bus.
- acc_ld_n  output  1  accumulator load (IA).
- acc_oe_n  output  1  accumulator drives the bus (EA).
- b_ld_n  output  1  B register load.
- alu_oe_n  output  1  ALU drives the bus.
- alu_sub  output  1  1 = ALU subtracts.
- out_ld_n  output  1  output register load.
- halted  output  1  1 while in HALT.
- busy  output  1  1 in any T-state.
- instr_cnt  output  CNT_W  retired-instruction count.

Decided: one clock (clk); asynchronous active-low reset (rst_n).

## Operation

- States: IDLE, T1, T2, T3, T4, T5, T6, HALT. Binary-encoded state register.
- Control word is decoded from the current state and, in T4–T6, from opcode. It has no combinational dependency on run.
- Every strobe not listed for a state is deasserted: `_n` outputs = 1, pc_inc = 0, alu_sub = 0.
- Fetch, all opcodes:
  - T1: pc_oe_n = 0, mar_ld_n = 0.
  - T2: pc_inc = 1.
  - T3: ram_oe_n = 0, ir_ld_n = 0.
- Execute:
  - LDA 0x0: T4 ir_oe_n = 0, mar_ld_n = 0; T5 ram_oe_n = 0, acc_ld_n = 0; T6 idle.
  - ADD 0x1: T4 as LDA; T5 ram_oe_n = 0, b_ld_n = 0; T6 alu_oe_n = 0, acc_ld_n = 0.
  - SUB 0x2: as ADD, plus alu_sub = 1 in T6 only.
  - OUT 0xE: T4 acc_oe_n = 0, out_ld_n = 0; T5 and T6 idle.
  - HLT 0xF: T4 all strobes deasserted; next state HALT.
  - All other opcodes: NOP, T4–T6 idle.
- Transitions:
  - IDLE→T1 when run = 1.
  - T1→T2→…→T6 unconditionally.
  - T6→T1 if run = 1, else T6→IDLE.
  - T4→HALT if opcode = 0xF.
  - HALT is exited only by reset. run is ignored in HALT.
- instr_cnt increments by 1 on the T6→(T1|IDLE) edge and on the T4→HALT edge. It wraps 2^CNT_W−1 → 0.

## Timing

- Reset, asynchronous: state = IDLE, instr_cnt = 0, halted = 0, busy = 0, all `_n` = 1, pc_inc = 0, alu_sub = 0. Deassertion takes effect at the next rising edge.
- Start latency: run sampled 1 at edge k → T1 strobes are valid during cycle k+1.
- Throughput: one instruction every 6 cycles with no gaps while run = 1. HLT takes 4 cycles, then stays in HALT.
- run dropping mid-instruction has no effect until T6. The instruction always completes.
- Reset asserted mid-instruction returns to IDLE immediately; partial strobes end at once. instr_cnt is not incremented for the aborted instruction.
- opcode changing during T4–T6 changes the decode combinationally. The IR is stable in those states by construction.
- busy = 1 exactly in T1–T6. halted = 1 exactly in HALT.

## Configuration

- SAP_CTRL_JMP_EN:
  - Defined: opcode 0x3 = JMP. T4 ir_oe_n = 0, pc_ld_n = 0; T5 and T6 idle.
  - Undefined: 0x3 is a NOP and pc_ld_n is tied to 1.
  - The pc_ld_n port exists in both builds.

## Test plan

- Reset check: assert rst_n = 0 mid-cycle → all `_n` = 1, pc_inc = 0, halted = 0, instr_cnt = 0, all immediately (before the next edge).
- LDA decode: run = 1, opcode = 0x0 → strobe sequence T1 {pc_oe_n, mar_ld_n}, T2 pc_inc, T3 {ram_oe_n, ir_ld_n}, T4 {ir_oe_n, mar_ld_n}, T5 {ram_oe_n, acc_ld_n}, T6 none; instr_cnt = 1 after 6 cycles.
- SUB decode: opcode = 0x2 → T5 b_ld_n = 0; T6 alu_oe_n = 0, acc_ld_n = 0, alu_sub = 1; alu_sub = 0 in every other state.
- Stop and halt:
  - run dropped in T3 of an OUT (0xE) → T4 has acc_oe_n = 0 and out_ld_n = 0, then IDLE after T6.
  - Next instruction HLT (0xF) → HALT after 4 cycles, halted = 1, and it stays there with run = 1 for 20 cycles.
- Counter wrap: 256 back-to-back NOPs (0x5) → instr_cnt returns to 0, with no idle cycle between T6 and T1.
- Jump opcode: opcode = 0x3 → T4 pc_ld_n = 0 with SAP_CTRL_JMP_EN defined; pc_ld_n = 1 throughout without it.
